// File: rtl/d_mshr_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_mshr_file_pkg
//  Description : Shared types for the dcache miss file (address packets,
//                memory tags, per-entry state and entry record).
//  Revision    : 1.0 - initial release
// ============================================================================
package d_mshr_file_pkg;

    localparam int c_dtag_bits         = 13;
    localparam int c_block_offset_bits = 3;
    localparam int c_zero_bits         = 16;
    localparam int c_mem_tag_bits      = 4;
    localparam int c_num_mem_tags      = 15;

    typedef logic [c_mem_tag_bits-1:0] MEM_TAG;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        PENDING  = 2'd1,
        WAIT_MEM = 2'd2
    } D_MSHR_STATE;

    typedef struct packed {
        logic [c_zero_bits-1:0]         zeros;
        logic [c_dtag_bits-1:0]         tag;
        logic [c_block_offset_bits-1:0] block_offset;
    } D_ADDR;

    typedef struct packed {
        logic  valid;
        D_ADDR addr;
    } D_ADDR_PACKET;

    typedef struct packed {
        D_MSHR_STATE            state;
        logic [c_dtag_bits-1:0] tag;
        MEM_TAG                 mem_tag;
    } D_MSHR_ENTRY;

    // Block-aligned address for a tag: upper bits and offset are zero.
    function automatic D_ADDR block_addr(input logic [c_dtag_bits-1:0] tag);
        D_ADDR a;
        a.zeros        = '0;
        a.tag          = tag;
        a.block_offset = '0;
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_mshr_file_psel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : psel_gen
//  Description : Priority selector; grant r is the r-th lowest set request bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module psel_gen #(
    parameter int WIDTH = 4,
    parameter int REQS  = 1
) (
    input  logic [WIDTH-1:0]           req,
    output logic [REQS-1:0][WIDTH-1:0] gnt_bus
);

    logic [WIDTH-1:0] w_remaining;
    logic [WIDTH-1:0] w_lowest;

    always_comb begin
        w_remaining = req;
        w_lowest    = '0;
        gnt_bus     = '0;
        for (int r = 0; r < REQS; r++) begin
            w_lowest    = w_remaining & (~w_remaining + {{(WIDTH-1){1'b0}}, 1'b1});
            gnt_bus[r]  = w_lowest;
            w_remaining = w_remaining & ~w_lowest;
        end
    end

endmodule
`default_nettype wire

// File: rtl/d_mshr_file.sv
`default_nettype none
// ============================================================================
//  Module      : d_mshr_file
//  Description : Fully associative dcache miss file: merges secondary misses,
//                issues one block request per cycle, retires fills by mem tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_mshr_file
    import d_mshr_file_pkg::*;
#(
    parameter int NUM_ENTRIES  = c_num_mem_tags,
    parameter int NUM_LD_PORTS = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  D_ADDR_PACKET [NUM_LD_PORTS-1:0]      miss_addrs,
    output logic [NUM_LD_PORTS-1:0]              miss_accepted,
    output logic                                 full,
    output D_ADDR_PACKET                         mem_req_addr,
    input  logic                                 mem_req_accepted,
    input  MEM_TAG                               current_req_tag,
    input  MEM_TAG                               mem_data_tag,
    output D_ADDR_PACKET                         fill_addr,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]     outstanding,
    output logic                                 err_unmatched_fill
);

    localparam int c_cnt_bits = $clog2(NUM_ENTRIES+1);

    D_MSHR_ENTRY r_entries [NUM_ENTRIES];
    D_MSHR_ENTRY w_next    [NUM_ENTRIES];
    logic        r_err;

    logic [NUM_ENTRIES-1:0]                   w_free;
    logic [NUM_ENTRIES-1:0]                   w_pending;
    logic [NUM_ENTRIES-1:0]                   w_fill_hit;
    logic                                     w_unmatched;
    logic [NUM_LD_PORTS-1:0][NUM_ENTRIES-1:0] w_free_gnt;
    logic [0:0][NUM_ENTRIES-1:0]              w_req_gnt_bus;
    logic [NUM_ENTRIES-1:0]                   w_req_gnt;
    logic [NUM_LD_PORTS-1:0][NUM_ENTRIES-1:0] w_alloc_oh;
    logic [NUM_LD_PORTS-1:0]                  w_port_alloc;
    logic [NUM_LD_PORTS-1:0]                  w_accept;
    logic [NUM_ENTRIES-1:0]                   w_gnt_sel;
    logic                                     w_hit;
    int                                       w_alloc_cnt;
    logic [c_cnt_bits-1:0]                    w_cnt;
    logic                                     w_unused_addr_bits;

    // ------------------------------------------------------------------
    // Entry status decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        w_free     = '0;
        w_pending  = '0;
        w_fill_hit = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            w_free[k]     = (r_entries[k].state == INVALID);
            w_pending[k]  = (r_entries[k].state == PENDING);
            w_fill_hit[k] = (mem_data_tag != '0) && (r_entries[k].state == WAIT_MEM)
                            && (r_entries[k].mem_tag == mem_data_tag);
        end
        w_unmatched = (mem_data_tag != '0) && (w_fill_hit == '0);
    end

    psel_gen #(
        .WIDTH (NUM_ENTRIES),
        .REQS  (NUM_LD_PORTS)
    ) u_free_sel (
        .req     (w_free),
        .gnt_bus (w_free_gnt)
    );

    psel_gen #(
        .WIDTH (NUM_ENTRIES),
        .REQS  (1)
    ) u_req_sel (
        .req     (w_pending),
        .gnt_bus (w_req_gnt_bus)
    );

    assign w_req_gnt = w_req_gnt_bus[0];

    // ------------------------------------------------------------------
    // Miss merge / allocation, oldest port first. The n-th allocating port
    // takes the n-th lowest free entry, so ports never collide.
    // ------------------------------------------------------------------
    always_comb begin
        w_alloc_oh   = '0;
        w_port_alloc = '0;
        w_accept     = '0;
        w_alloc_cnt  = 0;
        w_hit        = 1'b0;
        w_gnt_sel    = '0;
        for (int p = 0; p < NUM_LD_PORTS; p++) begin
            if (miss_addrs[p].valid) begin
                w_hit = 1'b0;
                for (int k = 0; k < NUM_ENTRIES; k++) begin
                    if (!w_free[k] && (r_entries[k].tag == miss_addrs[p].addr.tag)) begin
                        w_hit = 1'b1;
                    end
                end
                for (int q = 0; q < p; q++) begin
                    if (w_port_alloc[q] && (miss_addrs[q].addr.tag == miss_addrs[p].addr.tag)) begin
                        w_hit = 1'b1;
                    end
                end
                w_gnt_sel = '0;
                for (int r = 0; r < NUM_LD_PORTS; r++) begin
                    if (r == w_alloc_cnt) begin
                        w_gnt_sel = w_free_gnt[r];
                    end
                end
                if (w_hit) begin
                    w_accept[p] = 1'b1;
                end else if (w_gnt_sel != '0) begin
                    w_alloc_oh[p]   = w_gnt_sel;
                    w_port_alloc[p] = 1'b1;
                    w_accept[p]     = 1'b1;
                    w_alloc_cnt     = w_alloc_cnt + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: fill, request grant and allocation touch disjoint entries
    // (WAIT_MEM, PENDING and INVALID respectively).
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_entries;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (w_fill_hit[k]) begin
                w_next[k].state = INVALID;
            end
            if (w_req_gnt[k] && mem_req_accepted && (current_req_tag != '0)) begin
                w_next[k].state   = WAIT_MEM;
                w_next[k].mem_tag = current_req_tag;
            end
            for (int p = 0; p < NUM_LD_PORTS; p++) begin
                if (w_alloc_oh[p][k]) begin
                    w_next[k].state   = PENDING;
                    w_next[k].tag     = miss_addrs[p].addr.tag;
                    w_next[k].mem_tag = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                r_entries[k].state   <= INVALID;
                r_entries[k].tag     <= '0;
                r_entries[k].mem_tag <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_entries <= w_next;
            r_err     <= r_err | w_unmatched;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_addr = '0;
        fill_addr    = '0;
        w_cnt        = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (w_req_gnt[k]) begin
                mem_req_addr.valid = 1'b1;
                mem_req_addr.addr  = block_addr(r_entries[k].tag);
            end
            if (w_fill_hit[k]) begin
                fill_addr.valid = 1'b1;
                fill_addr.addr  = block_addr(r_entries[k].tag);
            end
            if (!w_free[k]) begin
                w_cnt = w_cnt + c_cnt_bits'(1);
            end
        end
    end

    assign outstanding        = w_cnt;
    assign full               = (w_free == '0);
    assign err_unmatched_fill = r_err;
    assign miss_accepted      = reset ? '0 : w_accept;

    always_comb begin
        w_unused_addr_bits = 1'b0;
        for (int p = 0; p < NUM_LD_PORTS; p++) begin
            w_unused_addr_bits = w_unused_addr_bits
                                 ^ (^miss_addrs[p].addr.zeros)
                                 ^ (^miss_addrs[p].addr.block_offset);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_d_mshr_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_mshr_file
//  Description : Scoreboard bench for d_mshr_file (4 entries, 2 load ports).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_mshr_file;
    import d_mshr_file_pkg::*;

    localparam int NE = 4;
    localparam int NP = 2;
    localparam int S_FREE = 0;
    localparam int S_PEND = 1;
    localparam int S_WAIT = 2;

    logic                 clock;
    logic                 reset;
    D_ADDR_PACKET [NP-1:0] miss_addrs;
    logic [NP-1:0]        miss_accepted;
    logic                 full;
    D_ADDR_PACKET         mem_req_addr;
    logic                 mem_req_accepted;
    MEM_TAG               current_req_tag;
    MEM_TAG               mem_data_tag;
    D_ADDR_PACKET         fill_addr;
    logic [2:0]           outstanding;
    logic                 err_unmatched_fill;

    d_mshr_file #(
        .NUM_ENTRIES  (NE),
        .NUM_LD_PORTS (NP)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .miss_addrs         (miss_addrs),
        .miss_accepted      (miss_accepted),
        .full               (full),
        .mem_req_addr       (mem_req_addr),
        .mem_req_accepted   (mem_req_accepted),
        .current_req_tag    (current_req_tag),
        .mem_data_tag       (mem_data_tag),
        .fill_addr          (fill_addr),
        .outstanding        (outstanding),
        .err_unmatched_fill (err_unmatched_fill)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NP-1:0] acc;
        logic          full;
        int            outst;
        logic          req_v;
        logic [31:0]   req_a;
        logic          fill_v;
        logic [31:0]   fill_a;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: one record per slot, plus the sticky error flag.
    int          m_st   [NE];
    logic [12:0] m_tag  [NE];
    logic [3:0]  m_mtag [NE];
    logic        m_err;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NE; k++) begin
            m_st[k] = S_FREE; m_tag[k] = '0; m_mtag[k] = '0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] blk(input logic [12:0] t);
        return {16'h0, t, 3'b000};
    endfunction

    // One clock of stimulus: drive inputs, predict outputs, advance model.
    task automatic step(input bit v0, input logic [12:0] t0, input bit v1, input logic [12:0] t1,
                        input bit acc, input logic [3:0] rtag, input logic [3:0] dtag);
        exp_t        e;
        bit          mv [NP];
        logic [12:0] mt [NP];
        int          req_i, fill_i, busy, slot;
        bit [NE-1:0] taken;
        logic [12:0] newtags[$];
        int          alloc_slot [NP];
        bit          hit;
        @(negedge clock);
        mv[0] = v0; mt[0] = t0; mv[1] = v1; mt[1] = t1;
        for (int p = 0; p < NP; p++) begin
            miss_addrs[p].valid             = mv[p];
            miss_addrs[p].addr.zeros        = '0;
            miss_addrs[p].addr.tag          = mt[p];
            miss_addrs[p].addr.block_offset = 3'($urandom);
        end
        mem_req_accepted = acc;
        current_req_tag  = rtag;
        mem_data_tag     = dtag;

        busy = 0; req_i = -1; fill_i = -1; taken = '0;
        for (int k = 0; k < NE; k++) begin
            if (m_st[k] != S_FREE) busy++;
            if (m_st[k] == S_PEND && req_i < 0) req_i = k;
            if (dtag != 0 && m_st[k] == S_WAIT && m_mtag[k] == dtag) fill_i = k;
        end
        e.acc = '0;
        for (int p = 0; p < NP; p++) begin
            alloc_slot[p] = -1;
            if (mv[p]) begin
                hit = 0;
                for (int k = 0; k < NE; k++) if (m_st[k] != S_FREE && m_tag[k] == mt[p]) hit = 1;
                foreach (newtags[i]) if (newtags[i] == mt[p]) hit = 1;
                if (hit) e.acc[p] = 1'b1;
                else begin
                    slot = -1;
                    for (int k = NE-1; k >= 0; k--) if (m_st[k] == S_FREE && !taken[k]) slot = k;
                    if (slot >= 0) begin
                        taken[slot] = 1'b1; alloc_slot[p] = slot;
                        newtags.push_back(mt[p]); e.acc[p] = 1'b1;
                    end
                end
            end
        end
        e.full   = (busy == NE);
        e.outst  = busy;
        e.req_v  = (req_i >= 0);
        e.req_a  = (req_i >= 0) ? blk(m_tag[req_i]) : 32'h0;
        e.fill_v = (fill_i >= 0);
        e.fill_a = (fill_i >= 0) ? blk(m_tag[fill_i]) : 32'h0;
        e.err    = m_err;
        exp_q.push_back(e);

        if (fill_i >= 0) m_st[fill_i] = S_FREE;
        if (dtag != 0 && fill_i < 0) m_err = 1'b1;
        if (req_i >= 0 && acc && rtag != 0) begin
            m_st[req_i] = S_WAIT; m_mtag[req_i] = rtag;
        end
        for (int p = 0; p < NP; p++) begin
            if (alloc_slot[p] >= 0) begin
                m_st[alloc_slot[p]] = S_PEND; m_tag[alloc_slot[p]] = mt[p]; m_mtag[alloc_slot[p]] = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_outstanding"}, outstanding, 0);
        chk({tagname, "_full"}, full, 0);
        chk({tagname, "_err"}, err_unmatched_fill, 0);
        chk({tagname, "_req_valid"}, mem_req_addr.valid, 0);
        chk({tagname, "_fill_valid"}, fill_addr.valid, 0);
        chk({tagname, "_miss_accepted"}, miss_accepted, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, with a live miss on port 0.
    task automatic reset_pulse();
        #3;
        reset = 1'b1;
        miss_addrs[0].valid    = 1'b1;
        miss_addrs[0].addr.tag = 13'h55;
        miss_addrs[1].valid    = 1'b0;
        mem_req_accepted = 1'b0;
        current_req_tag  = '0;
        mem_data_tag     = '0;
        #1;
        check_reset_outputs("async_reset");
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        miss_addrs = '0;
    endtask

    function automatic logic [3:0] free_mtag();
        int  start;
        logic [3:0] c;
        bit  used;
        start = $urandom_range(1, 15);
        for (int i = 0; i < 15; i++) begin
            c = 4'(((start - 1 + i) % 15) + 1);
            used = 0;
            for (int k = 0; k < NE; k++) if (m_st[k] == S_WAIT && m_mtag[k] == c) used = 1;
            if (!used) return c;
        end
        return 4'd0;
    endfunction

    task automatic rand_step();
        int   waits[$];
        int   r;
        logic [3:0] rtag, dtag;
        for (int k = 0; k < NE; k++) if (m_st[k] == S_WAIT) waits.push_back(k);
        rtag = ($urandom_range(0, 4) == 0) ? 4'd0 : free_mtag();
        r = $urandom_range(0, 99);
        dtag = 4'd0;
        if (r < 40 && waits.size() > 0) dtag = m_mtag[waits[$urandom_range(0, waits.size()-1)]];
        else if (r == 99) dtag = free_mtag();
        step(1'($urandom_range(0, 1)), 13'h10 + 13'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 13'h10 + 13'($urandom_range(0, 7)),
             ($urandom_range(0, 9) < 6), rtag, dtag);
    endtask

    // Monitor: compare DUT outputs against queued predictions each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("miss_accepted", miss_accepted, e.acc);
                chk("full", full, e.full);
                chk("outstanding", outstanding, e.outst);
                chk("req_valid", mem_req_addr.valid, e.req_v);
                if (e.req_v) chk("req_addr", mem_req_addr.addr, e.req_a);
                chk("fill_valid", fill_addr.valid, e.fill_v);
                if (e.fill_v) chk("fill_addr", fill_addr.addr, e.fill_a);
                chk("err_unmatched_fill", err_unmatched_fill, e.err);
            end
        end
    end

    initial begin
        reset = 1'b1;
        miss_addrs = '0;
        mem_req_accepted = 1'b0;
        current_req_tag = '0;
        mem_data_tag = '0;
        model_clear();
        repeat (2) @(negedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // Single miss through request, grant and fill
        step(1, 13'h100, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd3, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 4'd3);
        idle(1);

        // Same block on both ports in one cycle
        step(1, 13'h200, 1, 13'h200, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd5, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 4'd5);

        // Out-of-order fills
        step(1, 13'h10, 1, 13'h20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd1, 0);
        step(0, 0, 0, 0, 1, 4'd2, 0);
        step(0, 0, 0, 0, 0, 0, 4'd2);
        step(0, 0, 0, 0, 0, 0, 4'd1);
        idle(1);

        // Fill up, reject new block, merge resident block, refused grant
        step(1, 13'h10, 1, 13'h20, 0, 0, 0);
        step(1, 13'h30, 1, 13'h40, 0, 0, 0);
        idle(1);
        step(1, 13'h300, 1, 13'h10, 1, 4'd0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, 4'(i), 0);
        for (int i = 4; i >= 1; i--) step(0, 0, 0, 0, 0, 0, 4'(i));
        idle(1);

        // Unmatched fill is sticky until reset
        step(0, 0, 0, 0, 0, 0, 4'd7);
        idle(2);
        step(1, 13'h400, 0, 0, 0, 0, 0);
        reset_pulse();
        step(0, 0, 0, 0, 0, 0, 4'd9);
        idle(1);
        reset_pulse();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) reset_pulse();
            else rand_step();
        end

        repeat (3) @(negedge clock);
        #2;
        if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d_mshr_file.md
# d_mshr_file

Non-blocking data-cache miss tracker that replaces the single FIFO MSHR with a fully associative, parametrised miss file. It sits between the dcache load ports and the memory arbiter. It accepts misses from `NUM_LD_PORTS` load ports and merges secondary misses to blocks already in flight. It issues one memory request per cycle and retires fills in any order by matching the memory tag against every entry, then drives the dcache write address.

## Interface
- `NUM_ENTRIES`, default `` `NUM_MEM_TAGS ``: number of tracked outstanding blocks (≥2).
- `NUM_LD_PORTS`, default 2: miss input ports; port 0 is the oldest.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `miss_addrs` in `[NUM_LD_PORTS]` `D_ADDR_PACKET`: `valid` = load missed in dcache this cycle.
- `miss_accepted` out `[NUM_LD_PORTS]`: miss is tracked (allocated or merged); 0 = load must replay.
- `full` out 1: no INVALID entry.
- `mem_req_addr` out `D_ADDR_PACKET`: block request to arbiter; `block_offset`=0.
- `mem_req_accepted` in 1: arbiter granted `mem_req_addr` this cycle.
- `current_req_tag` in `MEM_TAG`: tag for the granted request; 0 = memory refused.
- `mem_data_tag` in `MEM_TAG`: nonzero = `mem_data` valid this cycle for that tag.
- `fill_addr` out `D_ADDR_PACKET`: dcache write address paired with this cycle's `mem_data`.
- `outstanding` out `$clog2(NUM_ENTRIES+1)`: count of non-INVALID entries.
- `err_unmatched_fill` out 1: sticky; set when a nonzero `mem_data_tag` matches no WAIT_MEM entry.

## Operation
- Per-entry state: INVALID → PENDING (allocated, not yet requested) → WAIT_MEM (holds `mem_tag`) → INVALID (on fill). Each entry holds block tag (`addr.tag`) and `mem_tag`.
- Miss handling proceeds port 0 → `NUM_LD_PORTS`-1 for each valid miss:
  - If the block tag matches any PENDING or WAIT_MEM entry, or a lower port's allocation this cycle: merge, `miss_accepted`=1, no allocation.
  - Otherwise allocate the lowest-index INVALID entry not already taken by a lower port, and set `miss_accepted`=1.
  - With no free entry: `miss_accepted`=0.
- A miss matching an entry being filled this cycle counts as merged (accepted). The dcache holds the line next cycle.
- Request: `mem_req_addr` = lowest-index PENDING entry, else valid=0.
  - `mem_req_accepted` && `current_req_tag`≠0: that entry → WAIT_MEM with `mem_tag`=`current_req_tag`.
  - Accepted with tag 0: entry stays PENDING and re-requests next cycle.
- Fill: `mem_data_tag`≠0 is matched against all WAIT_MEM entries; at most one matches.
  - On a match: `fill_addr`.valid=1, `addr`={zeros:0, tag:entry tag, block_offset:0}; entry → INVALID.
  - No match: `fill_addr`.valid=0 and `err_unmatched_fill` is set until reset.
- Simultaneous events:
  - Fill freeing entry k is not reusable for allocation in the same cycle; it is reusable next cycle.
  - Request acceptance and fill of different entries in one cycle are independent.
  - A fill can never target a PENDING entry.
- `full`, `outstanding` reflect registered state. `full` does not gate `miss_accepted`; merges succeed while full.

## Timing
- Reset (async assert): all entries INVALID, `err_unmatched_fill`=0. Outputs: `full`=0, `outstanding`=0, `mem_req_addr`.valid=0, `fill_addr`.valid=0, `miss_accepted`=0.
- `miss_accepted`, `fill_addr`, `mem_req_addr` are combinational, same cycle as inputs.
- An allocated entry is visible (PENDING, requestable) the next cycle; minimum miss-to-request latency is 1 cycle.
- State updates on `posedge clock`. Reset asserted mid-operation drops all in-flight entries. Fills arriving after reset for dropped tags set `err_unmatched_fill`.

## Structure
- Add to `sys_defs.svh`: `D_MSHR_STATE` enum {INVALID, PENDING, WAIT_MEM}, plus `D_MSHR_ENTRY` struct {state, tag (`` `DTAG_BITS ``), mem_tag}.
- Reuse `psel_gen` for free-entry and request selection. All other logic is inline in a single module.

## Test plan
Run with `NUM_ENTRIES`=4, `NUM_LD_PORTS`=2.
- Port 0 miss, tag 0x100 → accepted. Next cycle `mem_req_addr`=0x100. Accept with tag 3 → WAIT_MEM. Later `mem_data_tag`=3 → `fill_addr`.tag=0x100, `outstanding` 1→0.
- Both ports miss 0x200 in one cycle → both accepted, `outstanding`=1, exactly one request issued.
- Tags 0x10/0x20 get mem tags 1/2. Fill tag 2, then tag 1 → fills in that order, both entries freed.
- Fill 4 distinct tags: `full`=1.
  - New 0x300 miss → `miss_accepted`=0.
  - Miss to resident 0x10 → accepted.
- Grant with `current_req_tag`=0 → entry re-requested next cycle with the same address.
- `mem_data_tag`=7 with no match → `err_unmatched_fill`=1 and stays set. Async reset mid-cycle → cleared, `outstanding`=0 immediately.
